// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: walks each instruction through IF/ID/EX/MEM/WB and
// decodes per-state datapath strobes from the current state and the latched instruction fields.
module multicycle_ctrl #(
    parameter int I_LAT = 1,
    parameter int D_LAT = 1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [6:0]  OPCODE,
    input  logic [2:0]  FUNCT3,
    input  logic        BR_TAKEN,
    input  logic        HALT,
    output logic        IR_WE,
    output logic        PC_WE,
    output logic [1:0]  PC_SRC,
    output logic        RF_WE,
    output logic [1:0]  WB_SEL,
    output logic        D_MEM_WEN,
    output logic [3:0]  D_MEM_BE,
    output logic [2:0]  STATE,
    output logic        RETIRE,
    output logic        ILLEGAL,
    output logic [31:0] NUM_INST
);

    typedef enum logic [2:0] {
        S_IF     = 3'd0,
        S_ID     = 3'd1,
        S_EX     = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [3:0] I_LAST = 4'(I_LAT - 1);
    localparam logic [3:0] D_LAST = 4'(D_LAT - 1);

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [6:0]  op_reg;
    logic [2:0]  f3_reg;
    logic [31:0] num_reg;

    logic        opcode_legal;
    logic        if_last;
    logic        mem_last;
    logic [3:0]  store_be;

    assign if_last  = (cnt_reg == I_LAST);
    assign mem_last = (cnt_reg == D_LAST);
    assign STATE    = state_reg;
    assign NUM_INST = num_reg;

    // Legality is judged on the live opcode because the latch only captures it at the end of ID.
    always_comb begin
        opcode_legal = 1'b0;
        case (OPCODE)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_OP: opcode_legal = 1'b1;
            default:                          opcode_legal = 1'b0;
        endcase
    end

    always_comb begin
        store_be = 4'b0000;
        case (f3_reg)
            3'b000:  store_be = 4'b0001;
            3'b001:  store_be = 4'b0011;
            3'b010:  store_be = 4'b1111;
            default: store_be = 4'b0000;
        endcase
    end

    always_comb begin
        IR_WE     = 1'b0;
        PC_WE     = 1'b0;
        PC_SRC    = 2'd0;
        RF_WE     = 1'b0;
        WB_SEL    = 2'd0;
        D_MEM_WEN = 1'b1;
        D_MEM_BE  = 4'b0000;
        RETIRE    = 1'b0;
        ILLEGAL   = 1'b0;
        case (state_reg)
            S_IF: IR_WE = if_last;
            S_ID: begin
                // HALT wins over an illegal opcode, so no ILLEGAL pulse in that case.
                if (!HALT && !opcode_legal) begin
                    ILLEGAL = 1'b1;
                    PC_WE   = 1'b1;
                    RETIRE  = 1'b1;
                end
            end
            S_EX: begin
                if (op_reg == OP_BRANCH) begin
                    PC_WE  = 1'b1;
                    PC_SRC = BR_TAKEN ? 2'd1 : 2'd0;
                    RETIRE = 1'b1;
                end
            end
            S_MEM: begin
                if (op_reg == OP_STORE) begin
                    D_MEM_WEN = 1'b0;
                    D_MEM_BE  = store_be;
                    if (mem_last) begin
                        PC_WE  = 1'b1;
                        RETIRE = 1'b1;
                    end
                end
            end
            S_WB: begin
                RF_WE  = 1'b1;
                PC_WE  = 1'b1;
                RETIRE = 1'b1;
                case (op_reg)
                    OP_LOAD:          WB_SEL = 2'd1;
                    OP_JAL, OP_JALR:  WB_SEL = 2'd2;
                    OP_LUI:           WB_SEL = 2'd3;
                    default:          WB_SEL = 2'd0;
                endcase
                case (op_reg)
                    OP_JAL:  PC_SRC = 2'd1;
                    OP_JALR: PC_SRC = 2'd2;
                    default: PC_SRC = 2'd0;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_reg <= S_IF;
            cnt_reg   <= 4'd0;
            op_reg    <= 7'd0;
            f3_reg    <= 3'd0;
            num_reg   <= 32'd0;
        end else begin
            if (RETIRE) begin
                num_reg <= num_reg + 32'd1;
            end
            case (state_reg)
                S_IF: begin
                    if (if_last) begin
                        cnt_reg   <= 4'd0;
                        state_reg <= S_ID;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                S_ID: begin
                    op_reg <= OPCODE;
                    f3_reg <= FUNCT3;
                    if (HALT) begin
                        state_reg <= S_HALTED;
                    end else if (!opcode_legal) begin
                        state_reg <= S_IF;
                    end else begin
                        state_reg <= S_EX;
                    end
                end
                S_EX: begin
                    case (op_reg)
                        OP_BRANCH:         state_reg <= S_IF;
                        OP_LOAD, OP_STORE: state_reg <= S_MEM;
                        default:           state_reg <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_last) begin
                        cnt_reg   <= 4'd0;
                        state_reg <= (op_reg == OP_STORE) ? S_IF : S_WB;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                S_WB:     state_reg <= S_IF;
                S_HALTED: state_reg <= S_HALTED;
                default:  state_reg <= S_IF;
            endcase
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I datapath.
- Steps each instruction through fetch, decode, execute, memory and write-back states.
- Generates per-state strobes: PC/IR write enables, register-file write, data-memory control, write-back and next-PC selects.
- Sits beside the combinational instruction decoder and gates its outputs in time; it also counts retired instructions and handles halt.

Parameters:
- I_LAT, 1, instruction-memory read latency in cycles (1..15); IF lasts I_LAT cycles.
- D_LAT, 1, data-memory access latency in cycles (1..15); MEM lasts D_LAT cycles.

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  synchronous active-low reset.
- OPCODE  in  7  INSTR[6:0] from fetched instruction (valid from ID onward).
- FUNCT3  in  3  INSTR[14:12].
- BR_TAKEN  in  1  branch condition from ALU, valid in EX.
- HALT  in  1  halt request, sampled in ID.
- IR_WE  out  1  load instruction register.
- PC_WE  out  1  update PC.
- PC_SRC  out  2  0=PC+4, 1=PC+IMM, 2=(RS1+IMM)&~1.
- RF_WE  out  1  register-file write enable.
- WB_SEL  out  2  0=ALU, 1=load data, 2=PC+4, 3=IMM.
- D_MEM_WEN  out  1  data-memory write enable, active low.
- D_MEM_BE  out  4  byte enables.
- STATE  out  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4, HALTED=5.
- RETIRE  out  1  one-cycle pulse when an instruction completes.
- ILLEGAL  out  1  one-cycle pulse when ID sees an unknown opcode.
- NUM_INST  out  32  retired-instruction count.

Behaviour:
- All state updates on rising CLK; RSTn=0 at an edge forces the reset state regardless of current state (reset mid-instruction aborts it).
- Reset state: STATE=IF, wait counter=0, NUM_INST=0, latched opcode/funct3=0.
- Outputs are decoded from STATE, the latched opcode/funct3 and live BR_TAKEN. Defaults: all strobes 0, D_MEM_WEN=1, D_MEM_BE=0, PC_SRC=0, WB_SEL=0.
- Opcode and funct3 are latched on the ID cycle.
- IF: counter counts 0..I_LAT-1. IR_WE=1 only on the last IF cycle, then go to ID. The counter clears on leaving.
- ID: latch opcode/funct3.
  - HALT=1 -> HALTED. Takes priority over an illegal opcode.
  - Opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP} -> ILLEGAL=1, PC_WE=1, PC_SRC=0, RETIRE=1, go to IF.
  - Otherwise go to EX.
- EX:
  - BRANCH: PC_WE=1; PC_SRC=1 if BR_TAKEN else 0; RETIRE=1; go to IF.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- MEM: counter counts 0..D_LAT-1.
  - STORE: D_MEM_WEN=0 for all MEM cycles. D_MEM_BE by funct3: 000->0001, 001->0011, 010->1111, others->0000 (no write).
  - STORE, last cycle: PC_WE=1, RETIRE=1, go to IF.
  - LOAD: D_MEM_WEN=1; on the last cycle go to WB.
- WB: RF_WE=1, PC_WE=1, RETIRE=1, then go to IF.
  - WB_SEL: LOAD=1, JAL/JALR=2, LUI=3, else 0.
  - PC_SRC: JAL=1, JALR=2, else 0.
- HALTED: all strobes 0; stays until reset.
- NUM_INST increments by 1 on every cycle with RETIRE=1 and wraps at 2^32-1 -> 0.
- Cycles per instruction, with L=I_LAT and D=D_LAT:
  - branch: L+2
  - ALU, LUI, AUIPC, JAL, JALR: L+3
  - store: L+2+D
  - load: L+3+D
  - illegal: L+1

Test Plan:
- Reset, then ADDI (0010011) with I_LAT=1 -> STATE 0,1,2,4,0; RF_WE=1 and PC_WE=1 only in WB; NUM_INST=1 after 4 cycles.
- BEQ with BR_TAKEN=1, then BEQ with BR_TAKEN=0 -> each EX cycle has PC_WE=1; PC_SRC=1 then 0; no WB state; 3 cycles each.
- SH (funct3=001) with D_LAT=3 -> D_MEM_WEN=0 and D_MEM_BE=0011 for exactly 3 cycles; PC_WE on the third; RF_WE never 1; 6 cycles total.
- LW with I_LAT=2, D_LAT=2 -> IR_WE on the 2nd IF cycle; WB_SEL=1 and RF_WE=1 in WB; 7 cycles total.
- JALR, then opcode 1111111 -> JALR WB has WB_SEL=2, PC_SRC=2; illegal gives ILLEGAL pulse, PC_SRC=0, NUM_INST advances by 2.
- HALT=1 during ID -> STATE=5 and held with no strobes; RSTn=0 mid-MEM of a store -> next cycle STATE=0, D_MEM_WEN=1, NUM_INST=0.
